// File: rtl/cv32e40p_obi_apb_bridge.sv
// rtl/cv32e40p_obi_apb_bridge.sv - OBI data-port to APB bridge with timeout and sticky error capture
module cv32e40p_obi_apb_bridge #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   // OBI core side
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   // APB peripheral side
   output logic        psel_o,
   output logic        penable_o,
   output logic        pwrite_o,
   output logic [31:0] paddr_o,
   output logic [31:0] pwdata_o,
   output logic [3:0]  pstrb_o,
   input  logic        pready_i,
   input  logic [31:0] prdata_i,
   input  logic        pslverr_i,
   // error status
   output logic        err_o,
   output logic [31:0] err_addr_o,
   input  logic        err_clr_i
);

   // Counter is wide enough to hold TIMEOUT; keep at least one bit when timeout is disabled
   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [31:0]   TIMEOUT_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next_state;

   logic            r_we;
   logic [3:0]      r_be;
   logic [31:0]     r_addr;
   logic [31:0]     r_wdata;
   logic [CW-1:0]   r_cnt;
   logic            r_rvalid;
   logic [31:0]     r_rdata;
   logic            r_err;
   logic [31:0]     r_err_addr;

   logic            w_gnt;
   logic            w_psel;
   logic            w_penable;
   logic            w_grant;
   logic            w_timeout;
   logic            w_done;
   logic            w_err_event;

   // A grant is only possible in IDLE; req outside IDLE is ignored
   assign w_grant = (r_state == S_IDLE) && data_req_i;

   // Timeout fires on the last allowed wait cycle; pready wins when both coincide
   assign w_timeout = (TIMEOUT != 0) && (r_state == S_ACCESS) && !pready_i
                      && (r_cnt == CNT_LAST);

   // ACCESS ends on either a ready slave or an expired wait budget
   assign w_done = (r_state == S_ACCESS) && (pready_i || w_timeout);

   // Slave error is only meaningful together with pready; timeouts also count
   assign w_err_event = (r_state == S_ACCESS) && ((pready_i && pslverr_i) || w_timeout);

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: IDLE -> SETUP on grant, SETUP always one cycle, ACCESS until done
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_grant) w_next_state = S_SETUP;
         S_SETUP:  w_next_state = S_ACCESS;
         S_ACCESS: if (w_done) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Output decode: grant follows req in IDLE, psel/penable mark the APB phases
   always_comb begin
      w_gnt     = 1'b0;
      w_psel    = 1'b0;
      w_penable = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_gnt = data_req_i;
         end
         S_SETUP: begin
            w_psel = 1'b1;
         end
         S_ACCESS: begin
            w_psel    = 1'b1;
            w_penable = 1'b1;
         end
         default: begin
            w_gnt = 1'b0;
         end
      endcase
   end

   // Holding registers: captured on grant so APB address/data stay stable for the whole transfer
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_we    <= 1'b0;
         r_be    <= 4'b0000;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
      end else if (w_grant) begin
         r_we    <= data_we_i;
         r_be    <= data_be_i;
         r_addr  <= data_addr_i;
         r_wdata <= data_wdata_i;
      end
   end

   // Wait counter: cleared in SETUP so it starts at zero on ACCESS entry, saturates instead of wrapping
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (r_state == S_SETUP) begin
         r_cnt <= '0;
      end else if ((r_state == S_ACCESS) && !pready_i && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Response: one rvalid pulse per completion, rdata holds until the next completion
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rvalid <= 1'b0;
         r_rdata  <= 32'h0;
      end else begin
         r_rvalid <= w_done;
         if (w_done) begin
            if (w_timeout) begin
               r_rdata <= TIMEOUT_RDATA;
            end else if (r_we) begin
               r_rdata <= 32'h0;
            end else begin
               r_rdata <= prdata_i;
            end
         end
      end
   end

   // Sticky error: first failing address is kept; a clear coinciding with a new error loses to it
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_err      <= 1'b0;
         r_err_addr <= 32'h0;
      end else if (w_err_event && (!r_err || err_clr_i)) begin
         r_err      <= 1'b1;
         r_err_addr <= r_addr;
      end else if (err_clr_i) begin
         r_err      <= 1'b0;
         r_err_addr <= 32'h0;
      end
   end

   assign data_gnt_o    = w_gnt;
   assign data_rvalid_o = r_rvalid;
   assign data_rdata_o  = r_rdata;
   assign psel_o        = w_psel;
   assign penable_o     = w_penable;
   assign pwrite_o      = r_we;
   assign paddr_o       = r_addr;
   assign pwdata_o      = r_wdata;
   assign pstrb_o       = r_we ? r_be : 4'b0000;
   assign err_o         = r_err;
   assign err_addr_o    = r_err_addr;

endmodule

// File: tb/tb_cv32e40p_obi_apb_bridge.sv
// tb/tb_cv32e40p_obi_apb_bridge.sv - self-checking bench for the OBI to APB bridge
module tb_cv32e40p_obi_apb_bridge;

   localparam int TO = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        data_req_i = 1'b0;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic        data_we_i = 1'b0;
   logic [3:0]  data_be_i = 4'h0;
   logic [31:0] data_addr_i = 32'h0;
   logic [31:0] data_wdata_i = 32'h0;
   logic [31:0] data_rdata_o;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [31:0] paddr_o;
   logic [31:0] pwdata_o;
   logic [3:0]  pstrb_o;
   logic        pready_i = 1'b0;
   logic [31:0] prdata_i = 32'h0;
   logic        pslverr_i = 1'b0;
   logic        err_o;
   logic [31:0] err_addr_o;
   logic        err_clr_i = 1'b0;

   cv32e40p_obi_apb_bridge #(.TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
      .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
      .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i), .prdata_i(prdata_i),
      .pslverr_i(pslverr_i), .err_o(err_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      logic        clr;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [31:0] exp_eaddr;
      int          exp_lat;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   logic [31:0] last_rdata = 32'h0;
   logic        m_err = 1'b0;
   logic [31:0] m_eaddr = 32'h0;
   vec_t        tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Random core-side activity while the bridge is busy; it must be ignored
   task automatic noise();
      data_req_i   = 1'($urandom);
      data_we_i    = 1'($urandom);
      data_be_i    = 4'($urandom);
      data_addr_i  = $urandom;
      data_wdata_i = $urandom;
   endtask

   // Transaction-level reference: derives expected response and error state from the rules
   task automatic model(inout vec_t t);
      int  acc;
      logic to;
      to  = (t.waits >= TO);
      acc = to ? TO : t.waits + 1;
      t.exp_lat   = acc + 2;
      t.exp_rdata = to ? 32'hDEAD_BEEF : (t.we ? 32'h0 : t.prdata);
      if ((to || t.slverr) && (!m_err || t.clr)) begin
         m_err   = 1'b1;
         m_eaddr = t.addr;
      end else if (t.clr) begin
         m_err   = 1'b0;
         m_eaddr = 32'h0;
      end
      t.exp_err   = m_err;
      t.exp_eaddr = m_eaddr;
   endtask

   // One full OBI->APB transfer; entered and left at posedge+1 of an IDLE cycle
   task automatic xfer(input vec_t t, output int gcyc);
      int         k;
      logic       done;
      logic [3:0] exp_strb;
      exp_strb     = t.we ? t.be : 4'b0000;
      data_req_i   = 1'b1;
      data_we_i    = t.we;
      data_be_i    = t.be;
      data_addr_i  = t.addr;
      data_wdata_i = t.wdata;
      #1;
      chk("gnt_idle", data_gnt_o, 1'b1);
      gcyc = cyc;
      @(posedge clk_i); #1;
      noise();
      #1;
      chk("gnt_setup", data_gnt_o, 1'b0);
      chk("setup_phase", {psel_o, penable_o}, 2'b10);
      chk("rvalid_low", data_rvalid_o, 1'b0);
      chk("rdata_hold", data_rdata_o, last_rdata);
      chk("paddr", paddr_o, t.addr);
      chk("pwrite", pwrite_o, t.we);
      chk("pwdata", pwdata_o, t.wdata);
      chk("pstrb", pstrb_o, exp_strb);
      done = 1'b0;
      k = 0;
      while (!done && k < TO + 4) begin
         @(posedge clk_i); #1;
         noise();
         chk("access_phase", {psel_o, penable_o}, 2'b11);
         chk("paddr_hold", paddr_o, t.addr);
         chk("pstrb_hold", pstrb_o, exp_strb);
         if (k == t.waits) begin
            pready_i  = 1'b1;
            pslverr_i = t.slverr;
            prdata_i  = t.prdata;
            done      = 1'b1;
         end else begin
            pready_i  = 1'b0;
            pslverr_i = 1'($urandom);
            prdata_i  = $urandom;
            if (k == TO - 1) done = 1'b1;
         end
         err_clr_i = done ? t.clr : 1'b0;
         #1;
         chk("gnt_access", data_gnt_o, 1'b0);
         k++;
      end
      if (!done) chk("access_bound", 32'(k), 32'(TO));
      @(posedge clk_i); #1;
      data_req_i = 1'b0;
      pready_i   = 1'b0;
      pslverr_i  = 1'b0;
      err_clr_i  = 1'b0;
      prdata_i   = $urandom;
      #1;
      chk("rvalid", data_rvalid_o, 1'b1);
      chk("rdata", data_rdata_o, t.exp_rdata);
      chk("latency", 32'(cyc - gcyc), 32'(t.exp_lat));
      chk("idle_phase", {psel_o, penable_o}, 2'b00);
      chk("err", err_o, t.exp_err);
      chk("err_addr", err_addr_o, t.exp_eaddr);
      last_rdata = t.exp_rdata;
      m_err      = t.exp_err;
      m_eaddr    = t.exp_eaddr;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_psel", psel_o, 1'b0);
      chk("rst_penable", penable_o, 1'b0);
      chk("rst_rvalid", data_rvalid_o, 1'b0);
      chk("rst_rdata", data_rdata_o, 32'h0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_err_addr", err_addr_o, 32'h0);
      chk("rst_paddr", paddr_o, 32'h0);
      chk("rst_pwrite", pwrite_o, 1'b0);
      chk("rst_pwdata", pwdata_o, 32'h0);
      chk("rst_pstrb", pstrb_o, 4'h0);
      chk("rst_gnt", data_gnt_o, 1'b0);
   endtask

   initial begin
      int   g0, g1, g2;
      vec_t v;

      //            we    be     addr          wdata         wt prdata        slv   clr   exp_rdata     err   eaddr         lat
      tbl[0] = '{1'b0, 4'hF, 32'h1A10_0004, 32'h0,        0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 32'h0,        3};
      tbl[1] = '{1'b1, 4'h3, 32'h1A10_0010, 32'hCAFE_F00D, 3, 32'h7777_7777, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        6};
      tbl[2] = '{1'b0, 4'hF, 32'h1A10_2000, 32'h0,        0, 32'h55AA_55AA, 1'b1, 1'b0, 32'h55AA_55AA, 1'b1, 32'h1A10_2000, 3};
      tbl[3] = '{1'b0, 4'hF, 32'h1A10_3000, 32'h0,        0, 32'h0000_1111, 1'b1, 1'b0, 32'h0000_1111, 1'b1, 32'h1A10_2000, 3};
      tbl[4] = '{1'b1, 4'hC, 32'h1A10_4000, 32'h1111_2222, 0, 32'h3333_4444, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        3};
      tbl[5] = '{1'b0, 4'hF, 32'h1A10_5000, 32'h0,       20, 32'h9999_9999, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h1A10_5000, 18};
      tbl[6] = '{1'b0, 4'hF, 32'h1A10_6000, 32'h0,       15, 32'h0BAD_F00D, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h0,        18};
      tbl[7] = '{1'b0, 4'hF, 32'h1A10_7000, 32'h0,        0, 32'hA5A5_0000, 1'b1, 1'b1, 32'hA5A5_0000, 1'b1, 32'h1A10_7000, 3};
      tbl[8] = '{1'b0, 4'hF, 32'h1A10_8000, 32'h0,        0, 32'h0000_A5A5, 1'b1, 1'b1, 32'h0000_A5A5, 1'b1, 32'h1A10_8000, 3};
      tbl[9] = '{1'b1, 4'h1, 32'h1A10_A000, 32'hFEED_0001, 1, 32'h1234_0000, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        4};

      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk_reset_outputs();
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // Directed vectors
      for (int i = 0; i < 10; i++) begin
         xfer(tbl[i], g0);
         repeat (i % 2) begin
            @(posedge clk_i); #1;
            chk("gap_idle", psel_o, 1'b0);
         end
      end

      // Back-to-back zero-wait reads with request held: grants every third cycle
      v = '{1'b0, 4'hF, 32'h1A10_B000, 32'h0, 0, 32'h0101_0101, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0};
      model(v);
      xfer(v, g0);
      v.addr = 32'h1A10_B004; v.prdata = 32'h0202_0202;
      model(v);
      xfer(v, g1);
      v.addr = 32'h1A10_B008; v.prdata = 32'h0303_0303;
      model(v);
      xfer(v, g2);
      chk("b2b_gap1", 32'(g1 - g0), 32'd3);
      chk("b2b_gap2", 32'(g2 - g1), 32'd3);

      // Randomized transfers against the reference model
      for (int i = 0; i < 40; i++) begin
         v.we     = 1'($urandom);
         v.be     = 4'($urandom);
         v.addr   = {16'h1A10, 16'($urandom)};
         v.wdata  = $urandom;
         v.waits  = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
         v.prdata = $urandom;
         v.slverr = ($urandom_range(0, 3) == 0);
         v.clr    = ($urandom_range(0, 3) == 0);
         model(v);
         xfer(v, g0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk_i); #1;
            chk("rand_gap_idle", {psel_o, penable_o, data_rvalid_o}, 3'b000);
         end
      end

      // Reset during ACCESS: transfer aborted, no rvalid, everything back to zero
      data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
      data_addr_i = 32'h1A10_9000; data_wdata_i = 32'h5555_AAAA;
      #1;
      chk("rst_mid_gnt", data_gnt_o, 1'b1);
      @(posedge clk_i); #1;
      data_req_i = 1'b0;
      @(posedge clk_i); #1;
      chk("rst_mid_access", {psel_o, penable_o}, 2'b11);
      pready_i = 1'b0;
      rst_ni   = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      chk_reset_outputs();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         chk("rst_no_rvalid", data_rvalid_o, 1'b0);
      end
      m_err = 1'b0; m_eaddr = 32'h0; last_rdata = 32'h0;

      // Bridge is fully usable after the abort
      v = '{1'b0, 4'hF, 32'h1A10_C000, 32'h0, 2, 32'hBEEF_0001, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0};
      model(v);
      xfer(v, g0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cv32e40p_obi_apb_bridge.md
CV32E40P_OBI_APB_BRIDGE -- requirements
Module: cv32e40p_obi_apb_bridge

Purpose: sits directly downstream of the core data interface. Converts OBI-style req/gnt/rvalid transactions into APB transfers for peripheral space.

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the ACCESS-phase cycle limit; 0 disables the timeout.
REQ-002 The block SHALL have port clk_i, input, 1 bit: single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have the following OBI (core-side) ports:
- data_req_i, input, 1: core request.
- data_gnt_o, output, 1: request accepted.
- data_rvalid_o, output, 1: response valid.
- data_we_i, input, 1: write enable.
- data_be_i, input, 4: byte enables.
- data_addr_i, input, 32: address.
- data_wdata_i, input, 32: write data.
- data_rdata_o, output, 32: read data.
REQ-005 The block SHALL have the following APB (peripheral-side) ports:
- psel_o, output, 1.
- penable_o, output, 1.
- pwrite_o, output, 1.
- paddr_o, output, 32.
- pwdata_o, output, 32.
- pstrb_o, output, 4.
- pready_i, input, 1.
- prdata_i, input, 32.
- pslverr_i, input, 1.
REQ-006 The block SHALL have the following error-status ports:
- err_o, output, 1: sticky error.
- err_addr_o, output, 32: address of the first failing transfer.
- err_clr_i, input, 1: clears err_o and err_addr_o.

Function
REQ-007 The FSM SHALL have states IDLE, SETUP and ACCESS, and SHALL reset to IDLE.
REQ-008 data_gnt_o SHALL equal data_req_i while in IDLE and SHALL be 0 in all other states (combinational).
REQ-009 On grant, the block SHALL capture we/be/addr/wdata into holding registers and go to SETUP.
REQ-010 SETUP SHALL last exactly one cycle with psel_o=1 and penable_o=0, then go to ACCESS.
REQ-011 ACCESS SHALL drive psel_o=1 and penable_o=1 and SHALL remain there until pready_i=1 or a timeout occurs, then return to IDLE.
REQ-012 paddr_o, pwrite_o, pwdata_o and pstrb_o SHALL come from the holding registers and SHALL be stable throughout SETUP and ACCESS.
REQ-013 For reads, pstrb_o SHALL be forced to 4'b0000.
REQ-014 In IDLE, psel_o and penable_o SHALL both be 0.
REQ-015 data_rvalid_o SHALL be a registered single-cycle pulse in the cycle after ACCESS completes; exactly one rvalid SHALL be produced per grant.
REQ-016 data_rdata_o SHALL be registered:
- read completing with pready_i=1: prdata_i;
- write: 32'h0;
- timeout: 32'hDEAD_BEEF.
data_rdata_o SHALL hold its value until the next completion.
REQ-017 Minimum transfer timing SHALL be: grant at cycle N, SETUP at N+1, ACCESS at N+2 (pready_i=1), rvalid at N+3.
REQ-018 A new grant SHALL be allowed in the same cycle as the rvalid pulse, since the FSM is in IDLE then.
REQ-019 A timeout counter SHALL clear on ACCESS entry and increment each ACCESS cycle with pready_i=0.
REQ-020 When the timeout counter reaches TIMEOUT-1 with pready_i still 0, ACCESS SHALL complete as a timeout.
REQ-021 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate, never wrapping.
REQ-022 pready_i=1 in the same cycle as the timeout condition SHALL complete normally; pready_i has priority.
REQ-023 A completion with pslverr_i=1 (sampled only when pready_i=1), or a timeout, SHALL be an error event.
REQ-024 On an error event, if err_o=0, the block SHALL set err_o=1 next cycle and load err_addr_o with the transfer address.
REQ-025 If err_o is already 1, err_addr_o SHALL hold the first error address.
REQ-026 err_clr_i SHALL clear err_o and err_addr_o to 0 next cycle.
REQ-027 If err_clr_i coincides with an error event, the error event SHALL win: err_o=1 and the new address is captured.
REQ-028 pslverr_i, prdata_i and pready_i SHALL be ignored outside ACCESS.
REQ-029 data_req_i SHALL be ignored outside IDLE; the OBI protocol keeps it asserted until granted.

Reset
REQ-030 While rst_ni=0 at a clock edge, the next state SHALL be:
- FSM in IDLE;
- psel_o=0, penable_o=0;
- data_rvalid_o=0, data_rdata_o=0;
- err_o=0, err_addr_o=0;
- holding registers 0, so paddr_o=0, pwrite_o=0, pwdata_o=0, pstrb_o=0;
- timeout counter 0.
REQ-031 Reset asserted mid-transfer (SETUP or ACCESS) SHALL abort the transfer with no rvalid pulse.
REQ-032 data_gnt_o SHALL still follow REQ-008 combinationally during reset; the bench SHALL hold data_req_i=0 during reset.

Verification
REQ-033 Read, zero wait: req addr=0x1A10_0004, we=0; pready_i=1 in ACCESS, prdata_i=0x1234_5678 -> gnt at N, rvalid at N+3, rdata=0x1234_5678, err_o=0.
REQ-034 Write, 3 wait states: we=1, be=4'b0011, wdata=0xCAFE_F00D -> psel_o=1 for 5 cycles (SETUP plus 4 ACCESS), pstrb_o=0011, rvalid at N+6, rdata=0.
REQ-035 Slave error: read to 0x1A10_2000 with pslverr_i=1 and pready_i=1 -> rvalid pulse, err_o=1 next cycle, err_addr_o=0x1A10_2000; a second error to 0x1A10_3000 leaves err_addr_o unchanged.
REQ-036 Timeout (TIMEOUT=16): pready_i held 0 -> ACCESS lasts 16 cycles, rvalid with rdata=0xDEAD_BEEF, err_o=1; pready_i=1 on cycle 16 instead gives normal completion, err_o=0.
REQ-037 Back-to-back: data_req_i held 1 for 3 transfers with zero wait states -> grants at N, N+3, N+6; 3 rvalids; psel_o never drops between the ACCESS and SETUP phases except in the IDLE cycle.
REQ-038 Reset during ACCESS, and err_clr_i coinciding with an error event -> after reset all outputs are 0 and no rvalid occurs; in the coincident case err_o stays 1 with the new address.
